// File: rtl/store_rs_bank_pkg.sv
// Shared definitions for the store reservation station bank: default widths,
// store size encodings and the operand record used to describe a waiting operand.
package store_rs_bank_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_RB_INDEX  = 4;
  localparam int DEF_RB_SIZE   = 16;
  localparam int DEF_ENTRIES   = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic                     pending;
    logic [DEF_RB_INDEX-1:0]  tag;
    logic [DEF_WORD_SIZE-1:0] value;
  } operand_t;

endpackage

// File: rtl/store_rs_bank_if.sv
// Issue, CDB snoop and store-request signals of the store station bank.
// The station itself uses the slave modport; the issue/memory side uses master.
interface store_rs_bank_if
  import store_rs_bank_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RB_INDEX  = DEF_RB_INDEX,
  parameter int RB_SIZE   = DEF_RB_SIZE,
  parameter int ENTRIES   = DEF_ENTRIES
) ();

  localparam int LANES = WORD_SIZE / 8;
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic                         issue_valid;
  logic                         issue_ready;
  logic [RB_INDEX-1:0]          issue_dest;
  logic [1:0]                   issue_size;
  logic [WORD_SIZE-1:0]         issue_vi, issue_vj, issue_vk;
  logic                         issue_pi, issue_pj, issue_pk;
  logic [RB_INDEX-1:0]          issue_qi, issue_qj, issue_qk;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic                         out_valid;
  logic                         out_ready;
  logic [WORD_SIZE-1:0]         out_addr;
  logic [WORD_SIZE-1:0]         out_data;
  logic [LANES-1:0]             out_be;
  logic                         out_misaligned;
  logic [RB_INDEX-1:0]          out_dest;
  logic [OCC_W-1:0]             occupancy;

  modport master (
    output issue_valid, issue_dest, issue_size,
    output issue_vi, issue_vj, issue_vk, issue_pi, issue_pj, issue_pk,
    output issue_qi, issue_qj, issue_qk,
    output CDB_data_data, CDB_data_valid, out_ready,
    input  issue_ready, out_valid, out_addr, out_data, out_be,
    input  out_misaligned, out_dest, occupancy
  );

  modport slave (
    input  issue_valid, issue_dest, issue_size,
    input  issue_vi, issue_vj, issue_vk, issue_pi, issue_pj, issue_pk,
    input  issue_qi, issue_qj, issue_qk,
    input  CDB_data_data, CDB_data_valid, out_ready,
    output issue_ready, out_valid, out_addr, out_data, out_be,
    output out_misaligned, out_dest, occupancy
  );

endinterface

// File: rtl/store_rs_bank_operand.sv
// One operand slot of a station entry: captures the issued value, forwards a
// same-cycle CDB broadcast of its producer tag, and otherwise snoops the CDB.
module store_rs_operand
  import store_rs_bank_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RB_INDEX  = DEF_RB_INDEX,
  parameter int RB_SIZE   = DEF_RB_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_load,
  input  logic                         i_pending,
  input  logic [RB_INDEX-1:0]          i_tag,
  input  logic [WORD_SIZE-1:0]         i_value,
  input  logic [WORD_SIZE*RB_SIZE-1:0] i_cdbData,
  input  logic [RB_SIZE-1:0]           i_cdbValid,
  output logic                         o_pending,
  output logic [WORD_SIZE-1:0]         o_value
);

  logic                 r_pending;
  logic [RB_INDEX-1:0]  r_tag;
  logic [WORD_SIZE-1:0] r_value;
  logic                 w_issueHit, w_snoopHit;
  logic [WORD_SIZE-1:0] w_issueData, w_snoopData;

  // Tags beyond the last CDB channel never match, so no out-of-range select.
  always_comb begin
    w_issueHit  = 1'b0;
    w_issueData = '0;
    w_snoopHit  = 1'b0;
    w_snoopData = '0;
    for (int t = 0; t < RB_SIZE; t++) begin
      if (i_cdbValid[t] && i_tag == RB_INDEX'(t)) begin
        w_issueHit  = 1'b1;
        w_issueData = i_cdbData[t*WORD_SIZE +: WORD_SIZE];
      end
      if (i_cdbValid[t] && r_tag == RB_INDEX'(t)) begin
        w_snoopHit  = 1'b1;
        w_snoopData = i_cdbData[t*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_tag     <= '0;
      r_value   <= '0;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end else if (i_load) begin
      r_tag     <= i_tag;
      r_pending <= i_pending && !w_issueHit;
      r_value   <= (i_pending && w_issueHit) ? w_issueData : i_value;
    end else if (r_pending && w_snoopHit) begin
      r_pending <= 1'b0;
      r_value   <= w_snoopData;
    end
  end

  assign o_pending = r_pending;
  assign o_value   = r_value;

endmodule

// File: rtl/store_rs_bank.sv
// Multi-entry store reservation station: holds issued stores until their
// operands resolve, then hands the oldest ready one to a registered out slot.
module store_rs_bank
  import store_rs_bank_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int RB_INDEX  = DEF_RB_INDEX,
  parameter int RB_SIZE   = DEF_RB_SIZE,
  parameter int ENTRIES   = DEF_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  store_rs_bank_if.slave  bus
);

  localparam int LANES  = WORD_SIZE / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int OCC_W  = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]   r_busy;
  logic [RB_INDEX-1:0]  r_dest  [ENTRIES];
  logic [1:0]           r_size  [ENTRIES];
  // r_older[i][j] set means entry j was issued before entry i.
  logic [ENTRIES-1:0]   r_older [ENTRIES];
  logic [OCC_W-1:0]     r_occ;

  logic                 r_outValid, r_outMis;
  logic [WORD_SIZE-1:0] r_outAddr, r_outData;
  logic [LANES-1:0]     r_outBe;
  logic [RB_INDEX-1:0]  r_outDest;

  logic [ENTRIES-1:0]   w_pi, w_pj, w_pk, w_ready, w_oldest, w_issueHere;
  logic [WORD_SIZE-1:0] w_vi [ENTRIES];
  logic [WORD_SIZE-1:0] w_vj [ENTRIES];
  logic [WORD_SIZE-1:0] w_vk [ENTRIES];
  logic [IDX_W-1:0]     w_freeIdx, w_selIdx;
  logic                 w_anyFree, w_anySel, w_issueFire, w_load, w_mis;
  logic [WORD_SIZE-1:0] w_addr, w_data, w_selVi;
  logic [LANE_W-1:0]    w_lane;
  logic [LANES-1:0]     w_be;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    assign w_issueHere[e] = w_issueFire && (w_freeIdx == IDX_W'(e));
    assign w_ready[e]     = r_busy[e] && !w_pi[e] && !w_pj[e] && !w_pk[e];

    store_rs_operand #(.WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX), .RB_SIZE(RB_SIZE)) u_opI (
      .clk(clk), .reset(reset), .i_clear(flush), .i_load(w_issueHere[e]),
      .i_pending(bus.issue_pi), .i_tag(bus.issue_qi), .i_value(bus.issue_vi),
      .i_cdbData(bus.CDB_data_data), .i_cdbValid(bus.CDB_data_valid),
      .o_pending(w_pi[e]), .o_value(w_vi[e]));
    store_rs_operand #(.WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX), .RB_SIZE(RB_SIZE)) u_opJ (
      .clk(clk), .reset(reset), .i_clear(flush), .i_load(w_issueHere[e]),
      .i_pending(bus.issue_pj), .i_tag(bus.issue_qj), .i_value(bus.issue_vj),
      .i_cdbData(bus.CDB_data_data), .i_cdbValid(bus.CDB_data_valid),
      .o_pending(w_pj[e]), .o_value(w_vj[e]));
    store_rs_operand #(.WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX), .RB_SIZE(RB_SIZE)) u_opK (
      .clk(clk), .reset(reset), .i_clear(flush), .i_load(w_issueHere[e]),
      .i_pending(bus.issue_pk), .i_tag(bus.issue_qk), .i_value(bus.issue_vk),
      .i_cdbData(bus.CDB_data_data), .i_cdbValid(bus.CDB_data_valid),
      .o_pending(w_pk[e]), .o_value(w_vk[e]));
  end

  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    w_oldest  = w_ready;
    w_selIdx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_anyFree = 1'b1;
        w_freeIdx = IDX_W'(i);
      end
      for (int j = 0; j < ENTRIES; j++) begin
        if (w_ready[j] && r_older[i][j]) w_oldest[i] = 1'b0;
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_oldest[i]) w_selIdx = IDX_W'(i);
    end
    w_anySel = |w_oldest;
  end

  assign bus.issue_ready = !flush && w_anyFree;
  assign w_issueFire     = bus.issue_valid && bus.issue_ready;
  assign w_load          = w_anySel && (!r_outValid || bus.out_ready);

  always_comb begin
    w_selVi = w_vi[w_selIdx];
    w_addr  = w_vj[w_selIdx] + w_vk[w_selIdx];
    w_lane  = w_addr[LANE_W-1:0];
    case (r_size[w_selIdx])
      SZ_BYTE: begin
        w_be   = LANES'(1) << w_lane;
        w_data = {LANES{w_selVi[7:0]}};
        w_mis  = 1'b0;
      end
      SZ_HALF: begin
        w_be   = LANES'(3) << (w_lane & ~LANE_W'(1));
        w_data = {(LANES/2){w_selVi[15:0]}};
        w_mis  = w_lane[0];
      end
      default: begin
        w_be   = '1;
        w_data = w_selVi;
        w_mis  = (w_lane != '0);
      end
    endcase
  end

  // Flush beats issue, drain and snoop; a new entry is younger than every busy one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_occ  <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        r_dest[e]  <= '0;
        r_size[e]  <= '0;
        r_older[e] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
      r_occ  <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_load && w_selIdx == IDX_W'(e)) r_busy[e] <= 1'b0;
        if (w_issueHere[e]) begin
          r_busy[e]  <= 1'b1;
          r_dest[e]  <= bus.issue_dest;
          r_size[e]  <= bus.issue_size;
          r_older[e] <= r_busy;
        end else if (w_issueFire) begin
          r_older[e][w_freeIdx] <= 1'b0;
        end
      end
      r_occ <= r_occ + OCC_W'(w_issueFire) - OCC_W'(w_load);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outValid <= 1'b0;
      r_outAddr  <= '0;
      r_outData  <= '0;
      r_outBe    <= '0;
      r_outMis   <= 1'b0;
      r_outDest  <= '0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (!r_outValid || bus.out_ready) begin
      r_outValid <= w_anySel;
      if (w_anySel) begin
        r_outAddr <= w_addr;
        r_outData <= w_data;
        r_outBe   <= w_be;
        r_outMis  <= w_mis;
        r_outDest <= r_dest[w_selIdx];
      end
    end
  end

  assign bus.out_valid      = r_outValid;
  assign bus.out_addr       = r_outAddr;
  assign bus.out_data       = r_outData;
  assign bus.out_be         = r_outBe;
  assign bus.out_misaligned = r_outMis;
  assign bus.out_dest       = r_outDest;
  assign bus.occupancy      = r_occ;

endmodule

// File: doc/store_rs_bank.md
# store_rs_bank

Multi-entry store reservation station: parametrised successor of the single-slot store station. It holds up to `ENTRIES` issued stores and snoops the CDB data bus for pending base, offset and data operands. It selects the oldest fully-resolved store and hands it to the store unit through a registered valid/ready slot, with byte/half/word sizing and byte enables. It sits between the issue stage (CDB_inst side) and the memory store port, alongside the other functional-unit stations.

## Interface
- `WORD_SIZE`, 32, data/address width; must be a multiple of 8, byte lanes `LANES = WORD_SIZE/8`.
- `RB_INDEX`, 4, reorder-buffer tag width.
- `RB_SIZE`, 16, number of CDB data channels; must be ≤ 2^RB_INDEX.
- `ENTRIES`, 4, station depth; must be ≥ 2.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all entries and the out slot.
- `issue_valid` / `issue_ready`  in / out  1 / 1  issue handshake.
- `issue_dest`  in  RB_INDEX  reorder-buffer tag of the store.
- `issue_size`  in  2  0 = byte, 1 = half, 2 = word (full width); 3 is treated as word.
- `issue_vi`, `issue_vj`, `issue_vk`  in  WORD_SIZE each  store data, base, offset (offset already immediate-extended upstream).
- `issue_pi`, `issue_pj`, `issue_pk`  in  1 each  operand pending (1 = wait on tag).
- `issue_qi`, `issue_qj`, `issue_qk`  in  RB_INDEX each  producer tag, meaningful when pending.
- `CDB_data_data`  in  WORD_SIZE*RB_SIZE  flat CDB data, channel t at bits `[t*WORD_SIZE +: WORD_SIZE]`.
- `CDB_data_valid`  in  RB_SIZE  per-channel valid.
- `out_valid` / `out_ready`  out / in  1 / 1  store request handshake.
- `out_addr`, `out_data`  out  WORD_SIZE each  effective address, lane-replicated data.
- `out_be`  out  LANES  byte enables.
- `out_misaligned`  out  1  address not aligned for size.
- `out_dest`  out  RB_INDEX  tag of the presented store.
- `occupancy`  out  clog2(ENTRIES+1)  number of busy entries (out slot excluded).

## Operation
- Entry fields: busy, dest, size, per-operand {pending, tag, value}, age-matrix row.
- Issue: `issue_ready = !flush && any entry free`. On an accepted edge, write the lowest-index free entry. A pending operand whose tag has `CDB_data_valid` set in the same cycle is captured as resolved (same-cycle forwarding).
- Snoop: every edge, each busy entry's pending operand with `CDB_data_valid[tag]` captures `CDB_data_data` for that tag and clears pending. One channel may resolve any number of operands.
- Ready entry: busy and all three operands resolved.
- Age: ENTRIES×ENTRIES age matrix. A newly issued entry is younger than all busy entries. The oldest ready entry is the unique ready entry with no older ready entry.
- Out slot loads when empty or `out_valid && out_ready`. It takes the oldest ready entry, frees that entry the same edge, and computes:
  - `addr = Vj + Vk` mod 2^WORD_SIZE
  - `lane = addr[log2(LANES)-1:0]`
  - byte: `be = 1<<lane`, data = Vi[7:0] replicated across lanes.
  - half: `be = 3<<{lane[..:1],0}`, data = Vi[15:0] replicated, misaligned if lane[0].
  - word: `be = all ones`, data = Vi, misaligned if lane ≠ 0.
  - Misaligned stores are still presented, with `out_misaligned = 1`.
- Outputs are stable while `out_valid && !out_ready`.
- Flush: clears all busy bits, pending flags and the out slot; `out_valid` goes 0 next cycle. Flush wins over a simultaneous issue, handshake or snoop.
- Reset (async, mid-operation included): same clearing as flush, plus zero all output registers. Reset values: `out_valid` 0, `out_addr`/`out_data`/`out_be`/`out_dest` 0, `out_misaligned` 0, `occupancy` 0. `issue_ready` is 1 once reset is released.

## Timing
- Issue with all operands resolved at edge N: out slot loads at N+1, so `out_valid` is high in the cycle after N+1. Minimum latency is 2 edges.
- Operand resolved by CDB at edge M: entry is eligible at M+1.
- Back-to-back: one store per cycle when `out_ready` is held high.
- An entry freed at edge N is visible as free (`issue_ready`) in the cycle after N. There is no same-edge free-and-reuse.
- Full: `issue_ready` = 0 while all ENTRIES are busy, including the cycle in which the out slot is about to drain an entry.
- `occupancy` is updated on the same edge as issue and free.

## Structure
- Shared package: WORD_SIZE/RB_INDEX/RB_SIZE defaults, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), and the operand record {pending, tag, value}.
- One natural sub-module, `store_rs_operand`: a single operand slot with capture-on-issue, same-cycle forwarding and CDB snoop, instantiated three times per entry.
- Age matrix, select and out slot stay in the top module.

## Test plan
- Ready issue: base 0x100, offset 4, data 0xA5, word, dest 3, all resolved → at edge 2 after issue `out_addr` 0x104, `out_be` 0xF, `out_data` 0xA5, `out_dest` 3.
- CDB wake-up: issue with data pending on tag 5, then `CDB_data_valid[5]` with 0xDEAD two cycles later → store presented with `out_data` 0xDEAD one edge after the broadcast plus one.
- Ordering: issue A (pending tag 2), then B (ready), then resolve A → B is presented first. When both are ready in the same cycle, the older one wins.
- Sizing: byte store at addr 0x103, data 0x12 → `out_be` 0x8, `out_data` 0x12121212. Half store at 0x101 → `out_misaligned` 1.
- Full/backpressure: fill 4 entries with `out_ready` = 0 → `issue_ready` 0 and outputs held stable. Releasing `out_ready` drains one per cycle, in age order.
- Flush and reset: flush coincident with an issue and a pending handshake → `occupancy` 0 and `out_valid` 0 next cycle. Async `reset` low mid-cycle → outputs zero immediately.
